// File: rtl/self_attention_mm_ctrl.sv
`default_nettype none
// ============================================================================
// Module : self_attention_mm_ctrl
// Brief  : Tile sequencer for the Qn x Kn^T score matmul (fetch, wrapper ctrl,
//          tile handoff).
// Rev    : 1.0  initial release
// ============================================================================
module self_attention_mm_ctrl #(
  parameter int NUM_CORES_A = 4,
  parameter int NUM_CORES_B = 4,
  parameter int K_STEPS     = 8,
  parameter int ADDR_A_W    = $clog2(NUM_CORES_A*K_STEPS),
  parameter int ADDR_B_W    = $clog2(NUM_CORES_B*K_STEPS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           protocol_err,
  output logic                           rd_en,
  output logic [ADDR_A_W-1:0]            addr_a,
  output logic [ADDR_B_W-1:0]            addr_b,
  output logic                           mm_en,
  output logic                           mm_reset_acc,
  input  logic                           acc_done_wrap,
  input  logic                           systolic_finish_wrap,
  output logic                           tile_valid,
  input  logic                           tile_ready,
  output logic [$clog2(NUM_CORES_A)-1:0] tile_row,
  output logic [$clog2(NUM_CORES_B)-1:0] tile_col
);

  localparam int c_row_w = $clog2(NUM_CORES_A);
  localparam int c_col_w = $clog2(NUM_CORES_B);
  localparam int c_k_w   = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FETCH   = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_OUTPUT  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t             r_state;
  logic [c_row_w-1:0] r_row;
  logic [c_col_w-1:0] r_col;
  logic [c_k_w-1:0]   r_k;
  logic               r_err;

  logic w_last_k;
  logic w_last_col;
  logic w_last_row;
  logic w_wrap_err;

  assign w_last_k   = (r_k == c_k_w'(K_STEPS-1));
  assign w_last_col = (r_col == c_col_w'(NUM_CORES_B-1));
  assign w_last_row = (r_row == c_row_w'(NUM_CORES_A-1));
  // Wrapper pulses are only legal in the state that waits for them.
  assign w_wrap_err = (acc_done_wrap && (r_state != S_COMPUTE)) ||
                      (systolic_finish_wrap && (r_state != S_DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_row <= '0;
        r_col <= '0;
        r_k   <= '0;
        if (start && !abort) begin
          r_state <= S_CLEAR;
          r_err   <= 1'b0;
        end
      end else if (abort) begin
        r_state <= S_IDLE;
        r_row   <= '0;
        r_col   <= '0;
        r_k     <= '0;
      end else begin
        case (r_state)
          S_CLEAR: r_state <= S_FETCH;
          S_FETCH: r_state <= S_COMPUTE;
          S_COMPUTE: begin
            if (acc_done_wrap) begin
              if (w_last_k) begin
                r_k     <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_k     <= r_k + 1'b1;
                r_state <= S_FETCH;
              end
            end
          end
          S_DRAIN: begin
            if (systolic_finish_wrap) r_state <= S_OUTPUT;
          end
          S_OUTPUT: begin
            // Column index advances fastest; the pass ends after the last row.
            if (tile_ready) begin
              if (w_last_col) begin
                r_col <= '0;
                if (w_last_row) begin
                  r_row   <= '0;
                  r_state <= S_DONE;
                end else begin
                  r_row   <= r_row + 1'b1;
                  r_state <= S_CLEAR;
                end
              end else begin
                r_col   <= r_col + 1'b1;
                r_state <= S_CLEAR;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
      if (w_wrap_err) r_err <= 1'b1;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign protocol_err = r_err;
  assign rd_en        = (r_state == S_FETCH);
  assign mm_reset_acc = (r_state == S_CLEAR);
  assign mm_en        = (r_state == S_COMPUTE) || (r_state == S_DRAIN);
  assign tile_valid   = (r_state == S_OUTPUT);
  assign tile_row     = r_row;
  assign tile_col     = r_col;
  assign addr_a       = ADDR_A_W'(r_row) * ADDR_A_W'(K_STEPS) + ADDR_A_W'(r_k);
  assign addr_b       = ADDR_B_W'(r_col) * ADDR_B_W'(K_STEPS) + ADDR_B_W'(r_k);

endmodule
`default_nettype wire

// File: tb/tb_self_attention_mm_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_self_attention_mm_ctrl
// Brief  : Bench for self_attention_mm_ctrl with a reactive matmul wrapper model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_self_attention_mm_ctrl;

  localparam int NA = 2;
  localparam int NB = 2;
  localparam int K  = 4;
  localparam int AW = 3;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          protocol_err;
  logic          rd_en;
  logic [AW-1:0] addr_a;
  logic [BW-1:0] addr_b;
  logic          mm_en;
  logic          mm_reset_acc;
  logic          acc_done_wrap;
  logic          systolic_finish_wrap;
  logic          tile_valid;
  logic          tile_ready;
  logic [0:0]    tile_row;
  logic [0:0]    tile_col;

  logic w_acc      = 1'b0;
  logic w_fin      = 1'b0;
  logic inject_acc = 1'b0;
  assign acc_done_wrap        = w_acc | inject_acc;
  assign systolic_finish_wrap = w_fin;

  int checks = 0;
  int errors = 0;

  int acc_max = 0;
  int fin_min = 0;
  int fin_max = 0;
  bit pend_acc = 1'b0;
  bit pend_fin = 1'b0;
  int acc_d    = 0;
  int fin_d    = 0;
  int acc_seen = 0;

  int ev[$];
  int done_cnt = 0;

  self_attention_mm_ctrl #(
    .NUM_CORES_A (NA),
    .NUM_CORES_B (NB),
    .K_STEPS     (K),
    .ADDR_A_W    (AW),
    .ADDR_B_W    (BW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .abort                (abort),
    .busy                 (busy),
    .done                 (done),
    .protocol_err         (protocol_err),
    .rd_en                (rd_en),
    .addr_a               (addr_a),
    .addr_b               (addr_b),
    .mm_en                (mm_en),
    .mm_reset_acc         (mm_reset_acc),
    .acc_done_wrap        (acc_done_wrap),
    .systolic_finish_wrap (systolic_finish_wrap),
    .tile_valid           (tile_valid),
    .tile_ready           (tile_ready),
    .tile_row             (tile_row),
    .tile_col             (tile_col)
  );

  always #5 clk = ~clk;

  // Matmul wrapper: each fetched operand pair is accumulated after a random
  // number of enabled cycles; after K pairs the tile result settles likewise.
  always @(negedge clk) begin
    w_acc = 1'b0;
    w_fin = 1'b0;
    if (!rst_n || !busy) begin
      pend_acc = 1'b0;
      pend_fin = 1'b0;
      acc_seen = 0;
    end else if (pend_fin && mm_en) begin
      if (fin_d == 0) begin
        w_fin    = 1'b1;
        pend_fin = 1'b0;
      end else fin_d--;
    end else if (pend_acc && mm_en) begin
      if (acc_d == 0) begin
        w_acc    = 1'b1;
        pend_acc = 1'b0;
        acc_seen++;
        if (acc_seen == K) begin
          acc_seen = 0;
          pend_fin = 1'b1;
          fin_d    = $urandom_range(fin_max, fin_min);
        end
      end else acc_d--;
    end
    if (rst_n && busy && rd_en) begin
      pend_acc = 1'b1;
      acc_d    = $urandom_range(acc_max, 0);
    end
  end

  // Transaction log: accumulator clears, operand reads, accepted tiles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mm_reset_acc) ev.push_back(32'h10000);
      if (rd_en) ev.push_back(32'h20000 | (int'(addr_a) << 8) | int'(addr_b));
      if (tile_valid && tile_ready) ev.push_back(32'h30000 | (int'(tile_row) << 8) | int'(tile_col));
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_perr"}, 32'(protocol_err), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_mm_en"}, 32'(mm_en), 0);
    chk({tag, "_rst_acc"}, 32'(mm_reset_acc), 0);
    chk({tag, "_tvalid"}, 32'(tile_valid), 0);
    chk({tag, "_addr_a"}, 32'(addr_a), 0);
    chk({tag, "_addr_b"}, 32'(addr_b), 0);
    chk({tag, "_trow"}, 32'(tile_row), 0);
    chk({tag, "_tcol"}, 32'(tile_col), 0);
  endtask

  // A full pass: per tile in row-major order one clear, K reads, one handoff.
  task automatic check_pass_events(input string tag);
    int exp[$];
    for (int r = 0; r < NA; r++) begin
      for (int c = 0; c < NB; c++) begin
        exp.push_back(32'h10000);
        for (int k = 0; k < K; k++) exp.push_back(32'h20000 | ((r*K + k) << 8) | (c*K + k));
        exp.push_back(32'h30000 | (r << 8) | c);
      end
    end
    chk({tag, "_nevents"}, ev.size(), exp.size());
    for (int i = 0; i < exp.size() && i < ev.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), ev[i], exp[i]);
    chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!tile_valid && n < 500) begin
      step();
      n++;
    end
    chk({tag, "_valid_seen"}, 32'(tile_valid), 1);
  endtask

  initial begin
    int cyc;
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tile_ready = 1'b1; inject_acc = 1'b0;
    #12;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Pass 1: zero-wait wrapper, launch timing and minimum tile time.
    ev.delete(); done_cnt = 0;
    start = 1'b1; step(); start = 1'b0;
    chk("p1_c1_rst_acc", 32'(mm_reset_acc), 1);
    chk("p1_c1_busy", 32'(busy), 1);
    chk("p1_c1_rd_en", 32'(rd_en), 0);
    step();
    chk("p1_c2_rd_en", 32'(rd_en), 1);
    chk("p1_c2_addr_a", 32'(addr_a), 0);
    chk("p1_c2_rst_acc", 32'(mm_reset_acc), 0);
    step();
    chk("p1_c3_mm_en", 32'(mm_en), 1);
    cyc = 3;
    while (!done && cyc < 200) begin
      step();
      cyc++;
    end
    chk("p1_done_seen", 32'(done), 1);
    chk("p1_done_cycle", cyc, 1 + NA*NB*(1 + 2*K + 1 + 1));
    chk("p1_busy_in_done", 32'(busy), 1);
    step();
    chk("p1_busy_after", 32'(busy), 0);
    chk("p1_done_after", 32'(done), 0);
    check_pass_events("p1");

    // Pass 2: random wrapper delays, downstream stall on tile (0,1).
    acc_max = 5; fin_min = 0; fin_max = 5;
    ev.delete(); done_cnt = 0; tile_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    wait_valid("p2_t00");
    chk("p2_t00_row", 32'(tile_row), 0);
    chk("p2_t00_col", 32'(tile_col), 0);
    tile_ready = 1'b1; step(); tile_ready = 1'b0;
    wait_valid("p2_t01");
    chk("p2_t01_row", 32'(tile_row), 0);
    chk("p2_t01_col", 32'(tile_col), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("p2_stall_valid", 32'(tile_valid), 1);
      chk("p2_stall_row", 32'(tile_row), 0);
      chk("p2_stall_col", 32'(tile_col), 1);
      chk("p2_stall_rd_en", 32'(rd_en), 0);
      chk("p2_stall_mm_en", 32'(mm_en), 0);
    end
    tile_ready = 1'b1;
    wait_done("p2");
    step();
    check_pass_events("p2");

    // Pass 3: stray acc_done in OUTPUT, then abort in COMPUTE of tile (1,0).
    ev.delete(); done_cnt = 0; tile_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    wait_valid("p3_t00");
    inject_acc = 1'b1; step(); inject_acc = 1'b0;
    chk("p3_perr_set", 32'(protocol_err), 1);
    chk("p3_hold_valid", 32'(tile_valid), 1);
    chk("p3_hold_row", 32'(tile_row), 0);
    chk("p3_hold_col", 32'(tile_col), 0);
    chk("p3_hold_mm_en", 32'(mm_en), 0);
    step();
    chk("p3_perr_sticky", 32'(protocol_err), 1);
    chk("p3_hold_valid2", 32'(tile_valid), 1);
    tile_ready = 1'b1;
    n = 0;
    while (!(rd_en && addr_a == 3'd5) && n < 500) begin
      step();
      n++;
    end
    chk("p3_fetch_r1k1", 32'(rd_en && addr_a == 3'd5), 1);
    chk("p3_fetch_col0", 32'(addr_b), 1);
    step();
    chk("p3_in_compute", 32'(mm_en), 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("p3_abort_busy", 32'(busy), 0);
    chk("p3_abort_mm_en", 32'(mm_en), 0);
    chk("p3_abort_rd_en", 32'(rd_en), 0);
    chk("p3_abort_tvalid", 32'(tile_valid), 0);
    chk("p3_abort_done", 32'(done), 0);
    chk("p3_abort_perr", 32'(protocol_err), 1);
    repeat (5) step();
    chk("p3_no_done", done_cnt, 0);
    chk("p3_idle", 32'(busy), 0);

    // Pass 4: abort beats start in IDLE; accepted start clears the error.
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("p4_abort_wins_busy", 32'(busy), 0);
    chk("p4_abort_wins_rst_acc", 32'(mm_reset_acc), 0);
    chk("p4_abort_wins_perr", 32'(protocol_err), 1);
    ev.delete(); done_cnt = 0;
    start = 1'b1; step(); start = 1'b0;
    chk("p4_rst_acc_first", 32'(mm_reset_acc), 1);
    chk("p4_perr_cleared", 32'(protocol_err), 0);
    repeat (7) step();
    start = 1'b1; step(); start = 1'b0;
    chk("p4_busy_start_no_err", 32'(protocol_err), 0);
    wait_done("p4");
    step();
    check_pass_events("p4");
    chk("p4_perr_end", 32'(protocol_err), 0);

    // Pass 5: asynchronous reset while DRAIN waits on the wrapper.
    acc_max = 2; fin_min = 3; fin_max = 3;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!(pend_fin && mm_en) && n < 500) begin
      step();
      n++;
    end
    chk("p5_in_drain", 32'(pend_fin && mm_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("p5");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("p5_idle_after", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
